// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared helpers for the dual-clock FIFO pointer logic
// Purpose: pointer width helper, Gray/binary conversion functions and flag
//          reset values shared by the read-side pointer controller.
// Ports:   none (package).
package fifo_pkg;

    localparam logic EMPTY_RST  = 1'b1;
    localparam logic AEMPTY_RST = 1'b1;

    // Pointer width: one wrap bit above the RAM address.
    function automatic int ptrw(input int addrwidth);
        return addrwidth + 1;
    endfunction

    // Operands are zero-extended to 32 bits; callers truncate to their width.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it, so a
    // prefix XOR over shifted copies works for any zero-extended width.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = g;
        for (int i = 1; i < 32; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray_sync.sv
// rtl/fifo_gray_sync.sv - N-stage flop chain for clock-domain crossing
// Purpose: brings a Gray-coded pointer into the local clock domain.
// Ports:   clk_i  local clock
//          rst_i  asynchronous active-high reset, all stages clear to 0
//          d_i    asynchronous input word
//          q_o    output of the last stage
module fifo_gray_sync #(
    parameter int N = 2,
    parameter int W = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] stage_q [N];

    // Plain flop chain: no logic between stages.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < N; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[N-1];

endmodule

// File: rtl/fifo_rd_ptr_ctrl.sv
// rtl/fifo_rd_ptr_ctrl.sv - read-side pointer and status controller of the dual-clock FIFO
// Purpose: synchronizes the write Gray pointer, keeps the read pointers and
//          produces empty/almost-empty/count/underflow/data-valid.
// Config:  FIFO_SYNC3_EN selects a 3-stage synchronizer (default 2 stages).
// Ports:   rclk          read clock
//          rreset        asynchronous active-high reset
//          re            read request
//          wptr_gray_in  write pointer, Gray, from the write domain
//          raddr         RAM read address
//          ram_re        RAM read enable (accepted read)
//          rptr_gray     registered Gray read pointer to the write domain
//          empty         registered empty flag
//          aempty        registered almost-empty flag
//          rdcnt         registered words available
//          underflow     pulse on a read attempted while empty
//          dvld          RAM data valid, one cycle after an accepted read
module fifo_rd_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int ADDRWIDTH = 3,
    parameter int AEVAL     = 2
) (
    input  logic                 rclk,
    input  logic                 rreset,
    input  logic                 re,
    input  logic [ADDRWIDTH:0]   wptr_gray_in,
    output logic [ADDRWIDTH-1:0] raddr,
    output logic                 ram_re,
    output logic [ADDRWIDTH:0]   rptr_gray,
    output logic                 empty,
    output logic                 aempty,
    output logic [ADDRWIDTH:0]   rdcnt,
    output logic                 underflow,
    output logic                 dvld
);

    localparam int PTRW = ptrw(ADDRWIDTH);

`ifdef FIFO_SYNC3_EN
    localparam int SYNC_STAGES = 3;
`else
    localparam int SYNC_STAGES = 2;
`endif

    logic [PTRW-1:0] wptr_gray_s;
    logic [PTRW-1:0] wptr_bin_s;
    logic            accept;

    logic [PTRW-1:0] rptr_bin_q,  rptr_bin_d;
    logic [PTRW-1:0] rptr_gray_q, rptr_gray_d;
    logic [PTRW-1:0] rdcnt_q,     rdcnt_d;
    logic            empty_q,     empty_d;
    logic            aempty_q,    aempty_d;
    logic            underflow_q, underflow_d;
    logic            dvld_q,      dvld_d;

    fifo_gray_sync #(
        .N (SYNC_STAGES),
        .W (PTRW)
    ) u_wptr_sync (
        .clk_i (rclk),
        .rst_i (rreset),
        .d_i   (wptr_gray_in),
        .q_o   (wptr_gray_s)
    );

    assign wptr_bin_s = PTRW'(gray2bin(32'(wptr_gray_s)));

    // Gated by the registered empty, so a read can never pass the last word.
    assign accept = re & ~empty_q;

    // The next pointer feeds every flag, so a read and a synchronized write
    // pointer advance on the same edge are resolved consistently.
    always_comb begin
        rptr_bin_d  = rptr_bin_q + PTRW'(accept);
        rptr_gray_d = PTRW'(bin2gray(32'(rptr_bin_d)));
        empty_d     = (rptr_gray_d == wptr_gray_s);
        rdcnt_d     = wptr_bin_s - rptr_bin_d;
        aempty_d    = (rdcnt_d <= PTRW'(AEVAL));
        underflow_d = re & empty_q;
        dvld_d      = accept;
    end

    always_ff @(posedge rclk or posedge rreset) begin
        if (rreset) begin
            rptr_bin_q  <= '0;
            rptr_gray_q <= '0;
            rdcnt_q     <= '0;
            empty_q     <= EMPTY_RST;
            aempty_q    <= AEMPTY_RST;
            underflow_q <= 1'b0;
            dvld_q      <= 1'b0;
        end else begin
            rptr_bin_q  <= rptr_bin_d;
            rptr_gray_q <= rptr_gray_d;
            rdcnt_q     <= rdcnt_d;
            empty_q     <= empty_d;
            aempty_q    <= aempty_d;
            underflow_q <= underflow_d;
            dvld_q      <= dvld_d;
        end
    end

    assign raddr     = rptr_bin_q[ADDRWIDTH-1:0];
    assign ram_re    = accept;
    assign rptr_gray = rptr_gray_q;
    assign empty     = empty_q;
    assign aempty    = aempty_q;
    assign rdcnt     = rdcnt_q;
    assign underflow = underflow_q;
    assign dvld      = dvld_q;

endmodule

// File: tb/tb_fifo_rd_ptr_ctrl.sv
// tb/tb_fifo_rd_ptr_ctrl.sv - scoreboard bench for the FIFO read pointer controller
module tb_fifo_rd_ptr_ctrl;

    localparam int AW    = 3;
    localparam int AEV   = 2;
    localparam int DEPTH = 8;
    localparam int MOD   = 16;
`ifdef FIFO_SYNC3_EN
    localparam int STG = 3;
`else
    localparam int STG = 2;
`endif

    logic          rclk   = 1'b0;
    logic          rreset = 1'b1;
    logic          re     = 1'b0;
    logic [AW:0]   wptr_gray_in;
    logic [AW-1:0] raddr;
    logic          ram_re;
    logic [AW:0]   rptr_gray;
    logic          empty;
    logic          aempty;
    logic [AW:0]   rdcnt;
    logic          underflow;
    logic          dvld;

    typedef struct {
        int rptr;
        bit empty;
        bit aempty;
        int cnt;
        bit uf;
        bit dv;
    } exp_t;

    exp_t sb[$];
    int   ws[$];
    int   wr      = 0;
    int   m_rd    = 0;
    bit   m_empty = 1'b1;
    int   checks  = 0;
    int   failures = 0;

    function automatic logic [3:0] g4(input int v);
        logic [3:0] b;
        b = 4'(v);
        return b ^ (b >> 1);
    endfunction

    assign wptr_gray_in = g4(wr);

    fifo_rd_ptr_ctrl #(
        .ADDRWIDTH (AW),
        .AEVAL     (AEV)
    ) dut (
        .rclk         (rclk),
        .rreset       (rreset),
        .re           (re),
        .wptr_gray_in (wptr_gray_in),
        .raddr        (raddr),
        .ram_re       (ram_re),
        .rptr_gray    (rptr_gray),
        .empty        (empty),
        .aempty       (aempty),
        .rdcnt        (rdcnt),
        .underflow    (underflow),
        .dvld         (dvld)
    );

    always #5 rclk = ~rclk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: integer read pointer, history of written pointers
    // delayed by the synchronizer depth, occupancy by modular subtraction.
    initial begin
        exp_t e;
        int   wsync;
        int   cnt;
        bit   acc;
        bit   uf;
        repeat (STG) ws.push_back(0);
        forever begin
            @(posedge rclk or posedge rreset);
            if (rreset) begin
                m_rd    = 0;
                m_empty = 1'b1;
                ws.delete();
                repeat (STG) ws.push_back(0);
                sb.delete();
                e.rptr = 0; e.empty = 1'b1; e.aempty = 1'b1;
                e.cnt = 0; e.uf = 1'b0; e.dv = 1'b0;
                sb.push_back(e);
            end else begin
                wsync = ws.pop_front();
                ws.push_back(wr);
                acc     = re && !m_empty;
                uf      = re && m_empty;
                m_rd    = (m_rd + int'(acc)) % MOD;
                cnt     = (wsync - m_rd + MOD) % MOD;
                m_empty = (cnt == 0);
                e.rptr = m_rd; e.empty = m_empty; e.aempty = (cnt <= AEV);
                e.cnt = cnt; e.uf = uf; e.dv = acc;
                sb.push_back(e);
            end
        end
    end

    // Monitor: compares DUT state against the oldest expectation each cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge rclk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_rptr_gray", int'(rptr_gray), int'(g4(e.rptr)));
                chk("sb_raddr",     int'(raddr),     e.rptr % DEPTH);
                chk("sb_empty",     int'(empty),     int'(e.empty));
                chk("sb_aempty",    int'(aempty),    int'(e.aempty));
                chk("sb_rdcnt",     int'(rdcnt),     e.cnt);
                chk("sb_underflow", int'(underflow), int'(e.uf));
                chk("sb_dvld",      int'(dvld),      int'(e.dv));
                chk("sb_ram_re",    int'(ram_re),    int'(re && !e.empty));
            end
        end
    end

    task automatic write_n(input int n);
        repeat (n) begin
            @(posedge rclk); #1;
            wr = (wr + 1) % MOD;
        end
    endtask

    task automatic read_n(input int n);
        @(posedge rclk); #1;
        re = 1'b1;
        repeat (n) @(posedge rclk);
        #1;
        re = 1'b0;
    endtask

    task automatic settle();
        repeat (STG + 2) @(posedge rclk);
        #1;
    endtask

    task automatic reset_midstream();
        @(posedge rclk); #3;
        re     = 1'b1;
        rreset = 1'b1;
        #1;
        chk("rst_empty",     int'(empty),     1);
        chk("rst_aempty",    int'(aempty),    1);
        chk("rst_rdcnt",     int'(rdcnt),     0);
        chk("rst_rptr_gray", int'(rptr_gray), 0);
        chk("rst_dvld",      int'(dvld),      0);
        chk("rst_ram_re",    int'(ram_re),    0);
        wr = 0;
        repeat (2) @(posedge rclk);
        #1;
        rreset = 1'b0;
    endtask

    initial begin
        int lat;
        int n;
        int uf_cnt;
        int rr_cnt;
        int pr;

        repeat (3) @(posedge rclk);
        #1;
        rreset = 1'b0;
        chk("init_empty",  int'(empty),  1);
        chk("init_aempty", int'(aempty), 1);
        chk("init_rdcnt",  int'(rdcnt),  0);
        chk("init_dvld",   int'(dvld),   0);

        // Single write-pointer step: empty falls after the synchronizer plus flag flop.
        wr  = 1;
        lat = 0;
        for (int i = 1; i <= 8; i++) begin
            @(posedge rclk); #1;
            if (lat == 0 && !empty) lat = i;
        end
        chk("wstep_latency", lat, STG + 1);
        chk("wstep_rdcnt",   int'(rdcnt),  1);
        chk("wstep_aempty",  int'(aempty), 1);

        // Fill to full, then drain with re held high.
        write_n(7);
        settle();
        chk("full_rdcnt", int'(rdcnt), 8);
        chk("full_empty", int'(empty), 0);
        @(posedge rclk); #1;
        re = 1'b1;
        n  = 0;
        repeat (12) begin
            @(negedge rclk);
            if (ram_re) begin
                chk("drain_raddr", int'(raddr), n % DEPTH);
                n++;
            end
        end
        chk("drain_reads", n, 8);
        @(posedge rclk); #1;
        re = 1'b0;
        chk("drain_empty", int'(empty), 1);

        // Underflow: re high for three cycles while empty.
        uf_cnt = 0;
        rr_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            @(posedge rclk); #1;
            re = (k < 3);
            @(negedge rclk);
            uf_cnt += int'(underflow);
            rr_cnt += int'(ram_re);
        end
        chk("uf_pulses",    uf_cnt, 3);
        chk("uf_ram_re",    rr_cnt, 0);
        chk("uf_rptr_gray", int'(rptr_gray), int'(g4(8)));

        // Wrap: bring read pointer to 15, then write two more past the wrap.
        write_n(7);
        settle();
        read_n(7);
        write_n(2);
        settle();
        chk("wrap_rdcnt",     int'(rdcnt),     2);
        chk("wrap_rptr_gray", int'(rptr_gray), 8);
        chk("wrap_raddr",     int'(raddr),     7);
        read_n(1);
        chk("wrap2_rptr_gray", int'(rptr_gray), 0);
        chk("wrap2_raddr",     int'(raddr),     0);
        chk("wrap2_rdcnt",     int'(rdcnt),     1);

        // Randomized traffic with varying read pressure.
        for (int seg = 0; seg < 6; seg++) begin
            pr = (seg % 3 == 0) ? 20 : ((seg % 3 == 1) ? 85 : 50);
            repeat (500) begin
                @(posedge rclk); #1;
                re = ($urandom_range(0, 99) < pr);
                if (((wr - m_rd + MOD) % MOD) < DEPTH && $urandom_range(0, 1) == 1)
                    wr = (wr + 1) % MOD;
            end
        end

        // Reset mid-stream, then confirm nothing is accepted after release.
        reset_midstream();
        re     = 1'b1;
        rr_cnt = 0;
        repeat (4) begin
            @(negedge rclk);
            rr_cnt += int'(ram_re);
            @(posedge rclk); #1;
        end
        re = 1'b0;
        chk("post_rst_reads", rr_cnt, 0);
        repeat (2) @(posedge rclk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_rd_ptr_ctrl.md
Name: fifo_rd_ptr_ctrl

Overview:
Read-side pointer and status controller for the dual-clock FIFO. It brings the write-domain Gray pointer into the read clock domain through a multi-flop synchronizer and converts it to binary. It keeps the binary and Gray read pointers, drives the RAM read address, and generates empty, almost-empty, read-count, underflow and data-valid. It sits between the write-pointer Gray encoder (upstream, other clock domain) and the FIFO RAM read port.

Parameters:
ADDRWIDTH, 3, RAM address width; pointers are ADDRWIDTH+1 bits, the MSB being the wrap bit.
AEVAL, 2, almost-empty threshold in words; aempty is high when the count is at or below AEVAL. Legal range 0 to 2^ADDRWIDTH-1.

Ports:
rclk  in  1  read-domain clock; single clock for the whole block.
rreset  in  1  asynchronous, active-high reset.
re  in  1  read request from the consumer.
wptr_gray_in  in  ADDRWIDTH+1  write pointer, Gray coded, driven from the write clock domain (asynchronous to rclk).
raddr  out  ADDRWIDTH  RAM read address, equal to rptr_bin[ADDRWIDTH-1:0].
ram_re  out  1  RAM read enable; equals the accepted-read strobe.
rptr_gray  out  ADDRWIDTH+1  registered Gray read pointer, sent to the write domain.
empty  out  1  registered empty flag.
aempty  out  1  registered almost-empty flag.
rdcnt  out  ADDRWIDTH+1  registered count of words available to read.
underflow  out  1  one-cycle pulse when a read is attempted while empty.
dvld  out  1  RAM data valid, one cycle after an accepted read.

Behaviour:
- Reset is asynchronous, active-high. The following all clear to 0: synchronizer flops, rptr_bin, rptr_gray, rdcnt, underflow, dvld. empty and aempty are set to 1. Reset asserted mid-operation discards any in-flight dvld and takes effect immediately.
- Synchronizer: wptr_gray_in passes through 2 rclk flops to give wptr_gray_s, with no logic between the stages.
- Conversion: wptr_bin_s is the Gray-to-binary conversion of wptr_gray_s. Bit MSB is copied; each lower bit is the XOR of the next-higher binary bit and the Gray bit. This is combinational.
- accept = re & ~empty. ram_re = accept, combinational from re and the registered empty.
- rptr_bin_next = rptr_bin + accept, modulo 2^(ADDRWIDTH+1). Natural wrap, no saturation.
- Every rclk edge registers:
  - rptr_bin <= rptr_bin_next
  - rptr_gray <= rptr_bin_next ^ (rptr_bin_next >> 1)
  - empty <= (rptr_bin_next ^ (rptr_bin_next >> 1)) == wptr_gray_s
  - rdcnt <= (wptr_bin_s - rptr_bin_next), modulo 2^(ADDRWIDTH+1)
  - aempty <= (that same count) <= AEVAL
  - underflow <= re & empty
  - dvld <= accept
- Latency:
  - Write-pointer change to empty deassert: 3 rclk edges (2 synchronizer stages plus 1 flag register).
  - Accepted read to empty assert: same edge as the pointer update, so there is never an over-read.
- The flags are pessimistic by construction. A stale synchronized pointer can only over-report empty, never under-report it.
- Wrap-around: pointer 2^(ADDRWIDTH+1)-1 followed by one read gives 0. A full FIFO (count = 2^ADDRWIDTH) reports rdcnt = 2^ADDRWIDTH with empty = 0.
- re held high while empty: no pointer movement, ram_re = 0, and underflow pulses every such cycle.
- A read that empties the FIFO on the same cycle the synchronized write pointer advances: both are used in the same next-state equations, so the count and empty remain consistent.
- Only single-bit changes per rclk are expected on wptr_gray_in. Multi-bit jumps are out of scope.

Optional Feature:
FIFO_SYNC3_EN
- When defined: the synchronizer has 3 stages. Write-pointer-to-empty-deassert latency becomes 4 rclk edges. The reset value of the added stage is 0.
- When undefined: 2 stages as specified above.
- No other behaviour changes in either case.

Decomposition:
- Shared package fifo_pkg:
  - PTRW = ADDRWIDTH+1 width helper.
  - bin2gray and gray2bin functions.
  - Reset-value constants: EMPTY_RST = 1, AEMPTY_RST = 1.
- Sub-module: fifo_gray_sync, a parameterised N-stage, width-W flop chain with async active-high reset. It is instantiated once, with N = 2, or N = 3 under FIFO_SYNC3_EN.

Test Plan (ADDRWIDTH=3, AEVAL=2):
- Reset check: assert rreset mid-stream with re=1 -> within the same cycle empty=1, aempty=1, rdcnt=0, rptr_gray=0, dvld=0; after release, no reads are accepted.
- Write-pointer step: step wptr_gray_in 0->1 (binary 1) at t0 -> empty falls at the 3rd rclk edge (4th with FIFO_SYNC3_EN); rdcnt=1, aempty=1.
- Fill and drain: set wptr_gray_in to gray(8)=0b1100, then hold re=1 -> exactly 8 accepted reads with raddr 0..7 and dvld following each read by 1 cycle; rdcnt goes 8,7,...,0; aempty rises when rdcnt=2; empty rises on the edge of the 8th read.
- Wrap: preset via 15 write/read pairs, then write 2 more -> raddr wraps 7->0, rptr_gray goes 0b1000 -> 0b0000, and rdcnt stays correct (2).
- Underflow: re=1 for 3 cycles while empty -> underflow high for 3 cycles, ram_re=0, rptr unchanged.
- Simultaneous events: last word read on the same edge the synchronized wptr advances by 1 -> empty stays 0 and rdcnt=1.
